// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: CPU (m0) over UART DMA (m1) with a starvation
// guard, feeding a three-stage accept / bus issue / response pipeline.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        cpu_stall
);

  typedef struct packed {
    logic        valid;
    logic        owner;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t       cmd;
  logic [3:0] starve_cnt;
  logic       force_m1;
  logic       accept;
  logic       rsp_valid;
  logic       rsp_owner;

  assign force_m1 = m1_req && (starve_cnt == 4'(STARVE_MAX));

  // Requests seen during reset are held off until the cycle after.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (force_m1)
        m1_gnt = 1'b1;
      else if (m0_req)
        m0_gnt = 1'b1;
      else if (m1_req)
        m1_gnt = 1'b1;
    end
  end

  assign accept    = m0_gnt | m1_gnt;
  assign cpu_stall = m0_req & ~m0_gnt;

  assign bus_rd    = cmd.valid & ~cmd.wr;
  assign bus_wr    = cmd.valid & cmd.wr;
  assign bus_addr  = cmd.addr;
  assign bus_wdata = cmd.wdata;

  assign m0_rvalid = rsp_valid & ~rsp_owner;
  assign m1_rvalid = rsp_valid & rsp_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd        <= '0;
      starve_cnt <= '0;
      rsp_valid  <= 1'b0;
      rsp_owner  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      cmd.valid <= accept;
      if (accept) begin
        cmd.owner <= m1_gnt;
        cmd.wr    <= m1_gnt ? m1_wr    : m0_wr;
        cmd.addr  <= m1_gnt ? m1_addr  : m0_addr;
        cmd.wdata <= m1_gnt ? m1_wdata : m0_wdata;
      end

      if (!m1_req || m1_gnt)
        starve_cnt <= '0;
      else if (m0_gnt)
        starve_cnt <= starve_cnt + 4'd1;

      rsp_valid <= bus_rd;
      rsp_owner <= cmd.owner;
      // Capture only the owner's copy so the other port keeps its last data.
      if (bus_rd && !cmd.owner)
        m0_rdata <= bus_rdata;
      if (bus_rd && cmd.owner)
        m1_rdata <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_wr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_wr = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        cpu_stall;

  int n_chk = 0;
  int n_fail = 0;

  mem_bus_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: who wins, what is on the bus one cycle
  // after the win, and what read data comes back the cycle after that.
  bit          started = 0;
  int          lose;
  bit          iss_v, iss_wr, iss_own;
  logic [31:0] exp_addr, exp_wdata;
  bit          rsp_v, rsp_own;
  logic [31:0] rsp_data;
  logic [31:0] last_rd [2];

  function automatic void model_clear();
    lose = 0;
    iss_v = 0; iss_wr = 0; iss_own = 0;
    exp_addr = '0; exp_wdata = '0;
    rsp_v = 0; rsp_own = 0; rsp_data = '0;
    last_rd[0] = '0; last_rd[1] = '0;
  endfunction

  always @(negedge clk) begin
    bit e_g0, e_g1, forced;
    if (!started) begin
      if (reset === 1'b1) begin
        started = 1;
        model_clear();
      end
    end else begin
      forced = m1_req && (lose == STARVE);
      e_g1 = !reset && m1_req && (!m0_req || forced);
      e_g0 = !reset && m0_req && !e_g1;
      if (rsp_v) last_rd[rsp_own] = rsp_data;

      chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
      chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
      chk("cpu_stall", 32'(cpu_stall), 32'(m0_req && !e_g0));
      chk("bus_rd", 32'(bus_rd), 32'(iss_v && !iss_wr));
      chk("bus_wr", 32'(bus_wr), 32'(iss_v && iss_wr));
      chk("bus_addr", bus_addr, exp_addr);
      chk("bus_wdata", bus_wdata, exp_wdata);
      chk("m0_rvalid", 32'(m0_rvalid), 32'(rsp_v && !rsp_own));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(rsp_v && rsp_own));
      chk("m0_rdata", m0_rdata, last_rd[0]);
      chk("m1_rdata", m1_rdata, last_rd[1]);

      if (reset) begin
        model_clear();
      end else begin
        rsp_v = iss_v && !iss_wr;
        rsp_own = iss_own;
        rsp_data = bus_rdata;
        iss_v = e_g0 || e_g1;
        if (e_g1) begin
          iss_own = 1; iss_wr = m1_wr;
          exp_addr = m1_addr; exp_wdata = m1_wdata;
        end else if (e_g0) begin
          iss_own = 0; iss_wr = m0_wr;
          exp_addr = m0_addr; exp_wdata = m0_wdata;
        end
        if (!m1_req || e_g1) lose = 0;
        else if (e_g0) lose++;
      end
    end
  end

  logic [7:0] pat3;
  logic [6:0] seq4, exp4;
  logic [4:0] g6, rd6, wr6, rv6;
  bit         g0s, g1s;

  initial begin
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_gnt", 32'(m0_gnt | m1_gnt), 32'd0);
    chk("rst_bus_rd", 32'(bus_rd | bus_wr), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    cyc();

    // m0 read alone.
    m0_req = 1; m0_wr = 0; m0_addr = 32'h4000_0010;
    @(negedge clk);
    chk("d1_gnt", 32'(m0_gnt), 32'd1);
    chk("d1_stall_n", 32'(cpu_stall), 32'd0);
    cyc();
    m0_req = 0; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("d1_bus_rd", 32'(bus_rd), 32'd1);
    chk("d1_bus_addr", bus_addr, 32'h4000_0010);
    chk("d1_stall_n1", 32'(cpu_stall), 32'd0);
    cyc();
    bus_rdata = '0;
    @(negedge clk);
    chk("d1_rvalid", 32'(m0_rvalid), 32'd1);
    chk("d1_rdata", m0_rdata, 32'hDEAD_BEEF);
    cyc();

    // m1 write alone.
    m1_req = 1; m1_wr = 1;
    m1_addr = 32'h4000_0018; m1_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("d2_gnt", 32'(m1_gnt), 32'd1);
    cyc();
    m1_req = 0;
    @(negedge clk);
    chk("d2_bus_wr", 32'(bus_wr), 32'd1);
    chk("d2_bus_rd", 32'(bus_rd), 32'd0);
    chk("d2_bus_wdata", bus_wdata, 32'h1234_5678);
    cyc();
    @(negedge clk);
    chk("d2_rvalid", 32'(m0_rvalid | m1_rvalid), 32'd0);
    cyc();

    // Continuous contention: m0,m0,m0,m1 repeating.
    pat3 = 8'b1000_1000;
    m0_req = 1; m0_wr = 0; m0_addr = 32'h200;
    m1_req = 1; m1_wr = 0; m1_addr = 32'h300;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("d3_m1_gnt", 32'(m1_gnt), 32'(pat3[i]));
      chk("d3_m0_gnt", 32'(m0_gnt), 32'(!pat3[i]));
      chk("d3_stall", 32'(cpu_stall), 32'(pat3[i]));
      cyc();
    end
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    cyc();

    // m1 drop restarts the starvation count.
    seq4 = 7'b1111011;
    exp4 = 7'b1000000;
    m0_req = 1;
    for (int i = 0; i < 7; i++) begin
      m1_req = seq4[i];
      @(negedge clk);
      chk("d4_m1_gnt", 32'(m1_gnt), 32'(exp4[i]));
      cyc();
    end
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    cyc();

    // Reset right after an accepted read.
    m0_req = 1; m0_wr = 0; m0_addr = 32'h4000_0020;
    @(negedge clk);
    chk("d5_gnt", 32'(m0_gnt), 32'd1);
    cyc();
    m0_req = 0; reset = 1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    cyc();
    reset = 0; bus_rdata = '0;
    @(negedge clk);
    chk("d5_bus_rd", 32'(bus_rd), 32'd0);
    chk("d5_rvalid", 32'(m0_rvalid), 32'd0);
    chk("d5_bus_addr", bus_addr, 32'd0);
    chk("d5_rdata", m0_rdata, 32'd0);
    cyc();
    @(negedge clk);
    chk("d5_rvalid2", 32'(m0_rvalid), 32'd0);
    cyc();

    // Back-to-back read, write, read.
    g6 = 5'b00111; rd6 = 5'b01010; wr6 = 5'b00100; rv6 = 5'b10100;
    for (int i = 0; i < 5; i++) begin
      m0_req = (i < 3);
      m0_wr = (i == 1);
      m0_addr = 32'h100 + 32'(4 * i);
      m0_wdata = 32'h55;
      bus_rdata = 32'hA000 + 32'(i);
      @(negedge clk);
      chk("d6_gnt", 32'(m0_gnt), 32'(g6[i]));
      chk("d6_bus_rd", 32'(bus_rd), 32'(rd6[i]));
      chk("d6_bus_wr", 32'(bus_wr), 32'(wr6[i]));
      chk("d6_rvalid", 32'(m0_rvalid), 32'(rv6[i]));
      cyc();
    end

    // Random traffic obeying the hold-until-grant protocol.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      g0s = m0_gnt;
      g1s = m1_gnt;
      cyc();
      reset = ($urandom_range(99) == 0);
      if (m0_req && g0s) m0_req = 0;
      if (m1_req && g1s) m1_req = 0;
      if (!m0_req && $urandom_range(3) != 0) begin
        m0_req = 1;
        m0_wr = $urandom_range(1);
        m0_addr = $urandom;
        m0_wdata = $urandom;
      end
      if (!m1_req && $urandom_range(1) == 0) begin
        m1_req = 1;
        m1_wr = $urandom_range(1);
        m1_addr = $urandom;
        m1_wdata = $urandom;
      end
      bus_rdata = $urandom;
    end
    m0_req = 0; m1_req = 0; reset = 0;
    repeat (4) begin
      @(negedge clk);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
